cmd_init_sequencer: RTL and testbench
=====================================

// Module: cmd_init_sequencer
// PURPOSE
//  Sequences the CMD block through SD card identification/initialisation: CMD0, CMD8, CMD55/ACMD41 poll loop, CMD2, CMD3, CMD7.
//  Sits in the CLK_host domain between host control registers and CMD; owns CMD's new_cmd/cmd_index/cmd_arg while active.
//  Captures card type (CCS) and RCA; reports done or a coded error.
// PARAMETERS
//  MAX_ACMD41   1000      max CMD55/ACMD41 pairs before giving up (>=1)
//  RETRY_GAP    64        idle CLK_host cycles between ACMD41 busy reply and next CMD55
//  ACK_TIMEOUT  16        cycles allowed from new_cmd pulse to cmd_busy=1
//  WATCHDOG     4096      cycles allowed in WAIT_DONE before error
//  OCR_WINDOW   24'hFF8000 voltage window bits [23:0] of ACMD41 arg
// PORTS
//  CLK_host         in   1   clock
//  reset            in   1   synchronous, active-high
//  start            in   1   1-cycle pulse: begin sequence (ignored unless IDLE/DONE/ERROR)
//  cmd_busy         in   1   from CMD
//  cmd_complete     in   1   from CMD, response valid
//  timeout_error    in   1   from CMD, no response
//  response_status  in   32  from CMD, response payload
//  new_cmd          out  1   to CMD, 1-cycle issue pulse
//  cmd_index        out  6   to CMD
//  cmd_arg          out  32  to CMD
//  seq_busy         out  1   sequence in progress
//  init_done        out  1   level, card in transfer state
//  init_error       out  1   level, sequence aborted
//  error_code       out  3   valid when init_error
//  rca              out  16  relative card address
//  card_ccs         out  1   1 = SDHC/SDXC (high capacity)
//  card_v2          out  1   1 = CMD8 echoed correctly
// BEHAVIOUR
//  Reset (sync, any state): state IDLE; all outputs 0; counters cleared. Mid-sequence reset drops new_cmd same edge, no further commands.
//  FSM: IDLE -> ISSUE -> WAIT_ACK -> WAIT_DONE -> EVAL -> {ISSUE | GAP | DONE | ERROR}; GAP -> ISSUE.
//  start in IDLE/DONE/ERROR: clears init_done/init_error/error_code/rca/card_*, step=CMD0, ISSUE next cycle. start in other states: ignored.
//  ISSUE: new_cmd=1 for exactly one cycle; cmd_index/cmd_arg driven from ISSUE, held stable through EVAL.
//  WAIT_ACK: wait cmd_busy=1; >ACK_TIMEOUT cycles -> ERROR code 5.
//  WAIT_DONE: first cycle with cmd_complete or timeout_error ends wait (both high: timeout wins); >WATCHDOG cycles -> ERROR code 4.
//  EVAL (one cycle) per step:
//   CMD0  arg 0: complete or timeout both OK -> CMD8.
//   CMD8  arg 32'h000001AA: complete & resp[11:0]==12'h1AA -> card_v2=1 -> CMD55; complete & mismatch -> ERROR 1; timeout -> card_v2=0 -> CMD55.
//   CMD55 arg 0: complete -> ACMD41; timeout -> ERROR 3.
//   ACMD41 arg {1'b0,card_v2,6'b0,OCR_WINDOW}: timeout -> ERROR 3; resp[31]=1 -> card_ccs=resp[30] -> CMD2;
//     resp[31]=0 -> attempt count +1; count==MAX_ACMD41 -> ERROR 2, else GAP (RETRY_GAP cycles) -> CMD55.
//   CMD2  arg 0: complete -> CMD3; timeout -> ERROR 3.
//   CMD3  arg 0: complete -> rca=resp[31:16]; rca==0 -> ERROR 6, else CMD7; timeout -> ERROR 3.
//   CMD7  arg {rca,16'h0}: complete -> DONE; timeout -> ERROR 3.
//  seq_busy=1 in all states except IDLE/DONE/ERROR. DONE: init_done=1 held. ERROR: init_error=1, error_code held; no command issued.
//  Counters saturate, never wrap: attempt counter 10+ bits wide enough for MAX_ACMD41; watchdog counter clog2(WATCHDOG+1).
//  cmd_complete/timeout_error outside WAIT_DONE: ignored.
//  Latency: start -> first new_cmd = 1 cycle; EVAL -> next new_cmd = 1 cycle (no GAP).
// TESTING
//  T1 model card v2 ready on 3rd ACMD41, CMD3 resp 32'h12340000 -> indices 0,8,55,41,55,41,55,41,2,3,7; rca=16'h1234; card_v2=1; init_done=1.
//  T2 CMD8 timeout, ACMD41 resp 32'h80FF8000 -> card_v2=0, ACMD41 arg 32'h00FF8000, card_ccs=0, init_done=1.
//  T3 ACMD41 always resp[31]=0, MAX_ACMD41=4 -> exactly 4 ACMD41 issued, GAP of 64 cycles between, init_error=1, error_code=2.
//  T4 CMD8 resp[11:0]=12'h0AA -> ERROR code 1, no new_cmd after; start again -> restarts at CMD0 with outputs cleared.
//  T5 cmd_busy never rises after CMD2 issue -> error_code=5 after 16 cycles; CMD never answers -> error_code=4 after 4096.
//  T6 reset asserted in WAIT_DONE of ACMD41 -> next cycle IDLE, all outputs 0; start pulse during seq_busy ignored.

Source files
------------

// File: rtl/cmd_init_sequencer.sv
// SD card identification/initialisation sequencer.
// Drives the CMD block through CMD0, CMD8, the CMD55/ACMD41 poll loop, then
// CMD2, CMD3 and CMD7. It captures the card type (CCS, v2) and the RCA, and
// reports either done or a coded error.
//
// Ports
//   CLK_host        clock
//   reset           synchronous, active-high
//   start           1-cycle pulse; accepted only in IDLE/DONE/ERROR
//   cmd_busy        CMD block has accepted the command
//   cmd_complete    CMD block response valid
//   timeout_error   CMD block saw no response
//   response_status CMD block response payload
//   new_cmd         1-cycle issue pulse to CMD block
//   cmd_index       command index, held from issue through evaluation
//   cmd_arg         command argument, held from issue through evaluation
//   seq_busy        sequence in progress
//   init_done       card reached transfer state
//   init_error      sequence aborted; error_code tells why
//   error_code      1 CMD8 echo, 2 ACMD41 limit, 3 no response,
//                   4 watchdog, 5 no ack, 6 zero RCA
//   rca             relative card address
//   card_ccs        high-capacity card
//   card_v2         CMD8 echoed correctly
module cmd_init_sequencer #(
  parameter int unsigned MAX_ACMD41  = 1000,
  parameter int unsigned RETRY_GAP   = 64,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned WATCHDOG    = 4096,
  parameter logic [23:0] OCR_WINDOW  = 24'hFF8000
) (
  input  logic        CLK_host,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_busy,
  input  logic        cmd_complete,
  input  logic        timeout_error,
  input  logic [31:0] response_status,
  output logic        new_cmd,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        seq_busy,
  output logic        init_done,
  output logic        init_error,
  output logic [2:0]  error_code,
  output logic [15:0] rca,
  output logic        card_ccs,
  output logic        card_v2
);

  localparam int unsigned ATT_CLOG = $clog2(MAX_ACMD41 + 1);
  localparam int unsigned ATT_W    = (ATT_CLOG > 10) ? ATT_CLOG : 10;
  localparam int unsigned WD_W     = $clog2(WATCHDOG + 1);
  localparam int unsigned ACK_W    = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GAP_W    = (RETRY_GAP > 0) ? $clog2(RETRY_GAP + 1) : 1;

  // Value a counter holds on the last allowed cycle of its wait.
  localparam int unsigned ATT_LAST = (MAX_ACMD41  > 0) ? MAX_ACMD41  - 1 : 0;
  localparam int unsigned WD_LAST  = (WATCHDOG    > 0) ? WATCHDOG    - 1 : 0;
  localparam int unsigned ACK_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam int unsigned GAP_LAST = (RETRY_GAP   > 0) ? RETRY_GAP   - 1 : 0;

  localparam logic [2:0] ERR_CMD8_ECHO = 3'd1;
  localparam logic [2:0] ERR_ACMD41    = 3'd2;
  localparam logic [2:0] ERR_NO_RESP   = 3'd3;
  localparam logic [2:0] ERR_WATCHDOG  = 3'd4;
  localparam logic [2:0] ERR_NO_ACK    = 3'd5;
  localparam logic [2:0] ERR_RCA_ZERO  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT_ACK, ST_WAIT_DONE, ST_EVAL, ST_GAP, ST_DONE, ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    STEP_CMD0, STEP_CMD8, STEP_CMD55, STEP_ACMD41, STEP_CMD2, STEP_CMD3, STEP_CMD7
  } step_t;

  state_t             state_q, state_d;
  step_t              step_q, step_d;
  logic [2:0]         err_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [ACK_W-1:0]   ack_q, ack_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [31:0]        resp_q;
  logic               resp_to_q;
  logic               start_ok;

  logic               new_cmd_d, seq_busy_d, init_done_d, init_error_d;
  logic [5:0]         cmd_index_d;
  logic [31:0]        cmd_arg_d;
  logic [15:0]        rca_d;
  logic               ccs_d, v2_d;

  // Response bits [15:12] are not consulted by any step.
  logic unused_resp;
  assign unused_resp = ^resp_q[15:12];

  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE ||
                              state_q == ST_ERROR);

  // State register.
  always_ff @(posedge CLK_host) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, next step and error code.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    err_d   = error_code;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_ISSUE;
          step_d  = STEP_CMD0;
          err_d   = 3'd0;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (cmd_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_q >= ACK_W'(ACK_LAST)) begin
          state_d = ST_ERROR;
          err_d   = ERR_NO_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (cmd_complete || timeout_error) begin
          state_d = ST_EVAL;
        end else if (wd_q >= WD_W'(WD_LAST)) begin
          state_d = ST_ERROR;
          err_d   = ERR_WATCHDOG;
        end
      end
      ST_EVAL: begin
        state_d = ST_ISSUE;
        case (step_q)
          STEP_CMD0: step_d = STEP_CMD8;
          STEP_CMD8: begin
            // A v1 card does not answer CMD8; only a wrong echo is fatal.
            if (!resp_to_q && resp_q[11:0] != 12'h1AA) begin
              state_d = ST_ERROR;
              err_d   = ERR_CMD8_ECHO;
            end else begin
              step_d = STEP_CMD55;
            end
          end
          STEP_CMD55: begin
            if (resp_to_q) begin
              state_d = ST_ERROR;
              err_d   = ERR_NO_RESP;
            end else begin
              step_d = STEP_ACMD41;
            end
          end
          STEP_ACMD41: begin
            if (resp_to_q) begin
              state_d = ST_ERROR;
              err_d   = ERR_NO_RESP;
            end else if (resp_q[31]) begin
              step_d = STEP_CMD2;
            end else if (att_q >= ATT_W'(ATT_LAST)) begin
              state_d = ST_ERROR;
              err_d   = ERR_ACMD41;
            end else begin
              state_d = ST_GAP;
              step_d  = STEP_CMD55;
            end
          end
          STEP_CMD2: begin
            if (resp_to_q) begin
              state_d = ST_ERROR;
              err_d   = ERR_NO_RESP;
            end else begin
              step_d = STEP_CMD3;
            end
          end
          STEP_CMD3: begin
            if (resp_to_q) begin
              state_d = ST_ERROR;
              err_d   = ERR_NO_RESP;
            end else if (resp_q[31:16] == 16'h0) begin
              state_d = ST_ERROR;
              err_d   = ERR_RCA_ZERO;
            end else begin
              step_d = STEP_CMD7;
            end
          end
          STEP_CMD7: begin
            if (resp_to_q) begin
              state_d = ST_ERROR;
              err_d   = ERR_NO_RESP;
            end else begin
              state_d = ST_DONE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_GAP: begin
        if (gap_q >= GAP_W'(GAP_LAST)) state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, captured card data and counters.
  always_comb begin
    new_cmd_d    = (state_d == ST_ISSUE);
    seq_busy_d   = !(state_d == ST_IDLE || state_d == ST_DONE || state_d == ST_ERROR);
    init_done_d  = (state_d == ST_DONE);
    init_error_d = (state_d == ST_ERROR);
    cmd_index_d  = cmd_index;
    cmd_arg_d    = cmd_arg;
    rca_d        = rca;
    ccs_d        = card_ccs;
    v2_d         = card_v2;
    att_d        = att_q;

    if (start_ok) begin
      rca_d = 16'h0;
      ccs_d = 1'b0;
      v2_d  = 1'b0;
      att_d = '0;
    end

    if (state_q == ST_EVAL && !resp_to_q) begin
      case (step_q)
        STEP_CMD8: v2_d = (resp_q[11:0] == 12'h1AA);
        STEP_ACMD41: begin
          if (resp_q[31])                      ccs_d = resp_q[30];
          else if (att_q < ATT_W'(MAX_ACMD41)) att_d = att_q + ATT_W'(1);
        end
        STEP_CMD3: rca_d = resp_q[31:16];
        default: ;
      endcase
    end

    // Command fields load on entry to ISSUE; v2/rca may be updating this edge.
    if (state_d == ST_ISSUE) begin
      case (step_d)
        STEP_CMD0:   begin cmd_index_d = 6'd0;  cmd_arg_d = 32'h0; end
        STEP_CMD8:   begin cmd_index_d = 6'd8;  cmd_arg_d = 32'h0000_01AA; end
        STEP_CMD55:  begin cmd_index_d = 6'd55; cmd_arg_d = 32'h0; end
        STEP_ACMD41: begin cmd_index_d = 6'd41; cmd_arg_d = {1'b0, v2_d, 6'b0, OCR_WINDOW}; end
        STEP_CMD2:   begin cmd_index_d = 6'd2;  cmd_arg_d = 32'h0; end
        STEP_CMD3:   begin cmd_index_d = 6'd3;  cmd_arg_d = 32'h0; end
        STEP_CMD7:   begin cmd_index_d = 6'd7;  cmd_arg_d = {rca_d, 16'h0}; end
        default:     begin cmd_index_d = 6'd0;  cmd_arg_d = 32'h0; end
      endcase
    end

    // Per-state cycle counters: saturating, cleared outside their state.
    ack_d = '0;
    wd_d  = '0;
    gap_d = '0;
    if (state_q == ST_WAIT_ACK)
      ack_d = (ack_q < ACK_W'(ACK_TIMEOUT)) ? ack_q + ACK_W'(1) : ack_q;
    if (state_q == ST_WAIT_DONE)
      wd_d = (wd_q < WD_W'(WATCHDOG)) ? wd_q + WD_W'(1) : wd_q;
    if (state_q == ST_GAP)
      gap_d = (gap_q < GAP_W'(RETRY_GAP)) ? gap_q + GAP_W'(1) : gap_q;
  end

  // Datapath and output registers.
  always_ff @(posedge CLK_host) begin
    if (reset) begin
      step_q     <= STEP_CMD0;
      att_q      <= '0;
      wd_q       <= '0;
      ack_q      <= '0;
      gap_q      <= '0;
      resp_q     <= 32'h0;
      resp_to_q  <= 1'b0;
      new_cmd    <= 1'b0;
      cmd_index  <= 6'd0;
      cmd_arg    <= 32'h0;
      seq_busy   <= 1'b0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
      error_code <= 3'd0;
      rca        <= 16'h0;
      card_ccs   <= 1'b0;
      card_v2    <= 1'b0;
    end else begin
      step_q     <= step_d;
      att_q      <= att_d;
      wd_q       <= wd_d;
      ack_q      <= ack_d;
      gap_q      <= gap_d;
      // Timeout wins when both strobes arrive together.
      if (state_q == ST_WAIT_DONE && (cmd_complete || timeout_error)) begin
        resp_q    <= response_status;
        resp_to_q <= timeout_error;
      end
      new_cmd    <= new_cmd_d;
      cmd_index  <= cmd_index_d;
      cmd_arg    <= cmd_arg_d;
      seq_busy   <= seq_busy_d;
      init_done  <= init_done_d;
      init_error <= init_error_d;
      error_code <= err_d;
      rca        <= rca_d;
      card_ccs   <= ccs_d;
      card_v2    <= v2_d;
    end
  end

endmodule

// File: tb/tb_cmd_init_sequencer.sv
// Directed bench for cmd_init_sequencer with a small reactive card model.
module tb_cmd_init_sequencer;

  localparam int MAX_ACMD41  = 4;
  localparam int RETRY_GAP   = 64;
  localparam int ACK_TIMEOUT = 16;
  localparam int WATCHDOG    = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cmd_busy;
  logic        cmd_complete;
  logic        timeout_error;
  logic [31:0] response_status;
  logic        new_cmd;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        seq_busy;
  logic        init_done;
  logic        init_error;
  logic [2:0]  error_code;
  logic [15:0] rca;
  logic        card_ccs;
  logic        card_v2;

  cmd_init_sequencer #(
    .MAX_ACMD41 (MAX_ACMD41),
    .RETRY_GAP  (RETRY_GAP),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .WATCHDOG   (WATCHDOG),
    .OCR_WINDOW (24'hFF8000)
  ) dut (
    .CLK_host       (clk),
    .reset          (reset),
    .start          (start),
    .cmd_busy       (cmd_busy),
    .cmd_complete   (cmd_complete),
    .timeout_error  (timeout_error),
    .response_status(response_status),
    .new_cmd        (new_cmd),
    .cmd_index      (cmd_index),
    .cmd_arg        (cmd_arg),
    .seq_busy       (seq_busy),
    .init_done      (init_done),
    .init_error     (init_error),
    .error_code     (error_code),
    .rca            (rca),
    .card_ccs       (card_ccs),
    .card_v2        (card_v2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Card model configuration
  int          cfg_cmd8_mode;   // 0 echo, 1 no response, 2 bad echo
  int          cfg_ready_at;    // ACMD41 number that reports ready, 0 = never
  logic [31:0] cfg_ready_resp;
  logic [31:0] cfg_cmd3_resp;
  int          cfg_noack_idx;   // index never acknowledged, -1 none
  int          cfg_hang_idx;    // index acknowledged but never answered, -1 none
  bit          cfg_stop_in_hang;
  bit          cfg_extra_start;

  // Command log
  logic [5:0]  log_idx [64];
  logic [31:0] log_arg [64];
  int          log_issue [64];
  int          log_done [64];
  int          n_cmds;
  int          n_acmd41;
  int          end_cyc;

  logic [5:0]  exp_t1 [11];

  function automatic logic [31:0] card_resp(input logic [5:0] idx);
    case (idx)
      6'd8:    return (cfg_cmd8_mode == 2) ? 32'h0000_00AA : 32'h0000_01AA;
      6'd41:   return (cfg_ready_at != 0 && n_acmd41 >= cfg_ready_at) ? cfg_ready_resp
                                                                       : 32'h00FF_8000;
      6'd3:    return cfg_cmd3_resp;
      default: return 32'h0000_0900;
    endcase
  endfunction

  task automatic cfg_defaults();
    cfg_cmd8_mode    = 0;
    cfg_ready_at     = 1;
    cfg_ready_resp   = 32'h80FF_8000;
    cfg_cmd3_resp    = 32'h0001_0000;
    cfg_noack_idx    = -1;
    cfg_hang_idx     = -1;
    cfg_stop_in_hang = 1'b0;
    cfg_extra_start  = 1'b0;
  endtask

  // Leaves the caller on the negedge after the start edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Plays the CMD block and card until done/error (or a requested stop).
  // Called on a negedge; all sampling and driving happens on negedges.
  task automatic serve(input int budget, output bit ok);
    int cnt;
    bit pend;
    bit hang;
    int hang_n;
    bit extra_done;
    logic [5:0] idx;
    ok = 1'b0; pend = 1'b0; hang = 1'b0; hang_n = 0; cnt = 0;
    extra_done = 1'b0; idx = 6'd0;
    n_cmds = 0; n_acmd41 = 0; end_cyc = -1;
    for (int c = 0; c < budget; c++) begin
      cmd_complete  = 1'b0;
      timeout_error = 1'b0;
      start         = 1'b0;
      if (init_done || init_error) begin
        end_cyc = cyc;
        ok = 1'b1;
        break;
      end
      if (cfg_extra_start && !extra_done && n_cmds == 2) begin
        start = 1'b1;
        extra_done = 1'b1;
      end
      if (pend) begin
        if (hang) begin
          hang_n++;
          if (cfg_stop_in_hang && hang_n >= 4) begin
            ok = 1'b1;
            break;
          end
        end else begin
          cnt--;
          if (cnt == 0) begin
            pend = 1'b0;
            cmd_busy = 1'b0;
            log_done[n_cmds-1] = cyc;
            if (idx == 6'd8 && cfg_cmd8_mode == 1) begin
              timeout_error = 1'b1;
            end else begin
              cmd_complete    = 1'b1;
              response_status = card_resp(idx);
            end
          end
        end
      end
      if (new_cmd && n_cmds < 64) begin
        idx = cmd_index;
        log_idx[n_cmds]   = cmd_index;
        log_arg[n_cmds]   = cmd_arg;
        log_issue[n_cmds] = cyc;
        n_cmds++;
        if (idx == 6'd41) n_acmd41++;
        pend = 1'b1;
        cnt  = 3;
        hang = (int'(idx) == cfg_hang_idx) || (int'(idx) == cfg_noack_idx);
        cmd_busy = (int'(idx) != cfg_noack_idx);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (new_cmd !== 1'b0) begin miscompares++; $display("FAIL rst_new_cmd: got %b expected 0", new_cmd); end
    vectors++; if (seq_busy !== 1'b0) begin miscompares++; $display("FAIL rst_seq_busy: got %b expected 0", seq_busy); end
    vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
    vectors++; if (init_error !== 1'b0) begin miscompares++; $display("FAIL rst_init_error: got %b expected 0", init_error); end
    vectors++; if (error_code !== 3'd0) begin miscompares++; $display("FAIL rst_error_code: got %0d expected 0", error_code); end
    vectors++; if (rca !== 16'h0) begin miscompares++; $display("FAIL rst_rca: got %h expected 0000", rca); end
    vectors++; if ({card_ccs, card_v2} !== 2'b00) begin miscompares++; $display("FAIL rst_card: got %b expected 00", {card_ccs, card_v2}); end
    vectors++; if ({cmd_index, cmd_arg} !== 38'h0) begin miscompares++; $display("FAIL rst_cmd: got %h expected 0", {cmd_index, cmd_arg}); end
    reset = 1'b0;
  endtask

  // v2 card, ready on third ACMD41, high capacity, RCA 1234.
  task automatic test_full_v2();
    bit ok;
    cfg_defaults();
    cfg_ready_at   = 3;
    cfg_ready_resp = 32'hC0FF_8000;
    cfg_cmd3_resp  = 32'h1234_0000;
    exp_t1 = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd2, 6'd3, 6'd7};
    pulse_start();
    vectors++; if (new_cmd !== 1'b1) begin miscompares++; $display("FAIL t1_start_latency: new_cmd %b expected 1", new_cmd); end
    serve(2000, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL t1_finish: got %b expected 1", ok); end
    vectors++; if (n_cmds !== 11) begin miscompares++; $display("FAIL t1_cmd_count: got %0d expected 11", n_cmds); end
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (log_idx[i] !== exp_t1[i]) begin miscompares++; $display("FAIL t1_index[%0d]: got %0d expected %0d", i, log_idx[i], exp_t1[i]); end
    end
    vectors++; if (log_arg[1] !== 32'h0000_01AA) begin miscompares++; $display("FAIL t1_cmd8_arg: got %h expected 000001aa", log_arg[1]); end
    vectors++; if (log_arg[3] !== 32'h40FF_8000) begin miscompares++; $display("FAIL t1_acmd41_arg: got %h expected 40ff8000", log_arg[3]); end
    vectors++; if (log_arg[10] !== 32'h1234_0000) begin miscompares++; $display("FAIL t1_cmd7_arg: got %h expected 12340000", log_arg[10]); end
    // complete -> EVAL -> ISSUE
    vectors++; if (log_issue[2] - log_done[1] !== 2) begin miscompares++; $display("FAIL t1_eval_latency: got %0d expected 2", log_issue[2] - log_done[1]); end
    vectors++; if (log_issue[4] - log_done[3] !== RETRY_GAP + 2) begin miscompares++; $display("FAIL t1_gap: got %0d expected %0d", log_issue[4] - log_done[3], RETRY_GAP + 2); end
    vectors++; if (rca !== 16'h1234) begin miscompares++; $display("FAIL t1_rca: got %h expected 1234", rca); end
    vectors++; if ({card_v2, card_ccs} !== 2'b11) begin miscompares++; $display("FAIL t1_card: got %b expected 11", {card_v2, card_ccs}); end
    vectors++; if ({init_done, init_error, seq_busy} !== 3'b100) begin miscompares++; $display("FAIL t1_status: got %b expected 100", {init_done, init_error, seq_busy}); end
  endtask

  // v1 card: CMD8 unanswered, standard capacity.
  task automatic test_v1_card();
    bit ok;
    cfg_defaults();
    cfg_cmd8_mode  = 1;
    cfg_ready_resp = 32'h80FF_8000;
    pulse_start();
    vectors++; if ({rca, card_v2, card_ccs, init_done} !== 19'h0) begin miscompares++; $display("FAIL t2_start_clear: got %h expected 0", {rca, card_v2, card_ccs, init_done}); end
    serve(2000, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL t2_finish: got %b expected 1", ok); end
    vectors++; if (n_cmds !== 7) begin miscompares++; $display("FAIL t2_cmd_count: got %0d expected 7", n_cmds); end
    vectors++; if (log_arg[3] !== 32'h00FF_8000) begin miscompares++; $display("FAIL t2_acmd41_arg: got %h expected 00ff8000", log_arg[3]); end
    vectors++; if ({card_v2, card_ccs} !== 2'b00) begin miscompares++; $display("FAIL t2_card: got %b expected 00", {card_v2, card_ccs}); end
    vectors++; if (rca !== 16'h0001) begin miscompares++; $display("FAIL t2_rca: got %h expected 0001", rca); end
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL t2_done: got %b expected 1", init_done); end
  endtask

  // Bad CMD8 echo, then a clean restart.
  task automatic test_cmd8_error_restart();
    bit ok;
    int extra;
    cfg_defaults();
    cfg_cmd8_mode = 2;
    pulse_start();
    serve(500, ok);
    vectors++; if ({ok, init_error, error_code} !== 5'b11_001) begin miscompares++; $display("FAIL t4_error: got %b expected 11001", {ok, init_error, error_code}); end
    vectors++; if (n_cmds !== 2) begin miscompares++; $display("FAIL t4_cmd_count: got %0d expected 2", n_cmds); end
    extra = 0;
    repeat (50) begin @(negedge clk); if (new_cmd) extra++; end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL t4_quiet: got %0d commands expected 0", extra); end
    cfg_cmd8_mode = 0;
    cfg_cmd3_resp = 32'hABCD_0000;
    pulse_start();
    vectors++; if ({init_error, error_code} !== 4'b0000) begin miscompares++; $display("FAIL t4_restart_clear: got %b expected 0000", {init_error, error_code}); end
    vectors++; if ({new_cmd, cmd_index} !== {1'b1, 6'd0}) begin miscompares++; $display("FAIL t4_restart_cmd0: got %b/%0d expected 1/0", new_cmd, cmd_index); end
    serve(2000, ok);
    vectors++; if ({ok, init_done, rca} !== {2'b11, 16'hABCD}) begin miscompares++; $display("FAIL t4_restart_done: got %b/%b/%h expected 1/1/abcd", ok, init_done, rca); end
  endtask

  // ACMD41 never ready: limit reached after MAX_ACMD41 attempts.
  task automatic test_acmd41_limit();
    bit ok;
    int extra;
    cfg_defaults();
    cfg_ready_at = 0;
    pulse_start();
    serve(3000, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL t3_finish: got %b expected 1", ok); end
    vectors++; if (n_acmd41 !== MAX_ACMD41) begin miscompares++; $display("FAIL t3_acmd41_count: got %0d expected %0d", n_acmd41, MAX_ACMD41); end
    vectors++; if ({init_error, error_code} !== 4'b1010) begin miscompares++; $display("FAIL t3_error: got %b/%0d expected 1/2", init_error, error_code); end
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (log_issue[4 + 2*g] - log_done[3 + 2*g] !== RETRY_GAP + 2) begin
        miscompares++;
        $display("FAIL t3_gap[%0d]: got %0d expected %0d", g, log_issue[4 + 2*g] - log_done[3 + 2*g], RETRY_GAP + 2);
      end
    end
    extra = 0;
    repeat (100) begin @(negedge clk); if (new_cmd) extra++; end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL t3_quiet: got %0d commands expected 0", extra); end
  endtask

  // No acknowledge on CMD2; then no response at all to CMD0.
  task automatic test_timeouts();
    bit ok;
    int dt;
    cfg_defaults();
    cfg_noack_idx = 2;
    pulse_start();
    serve(1000, ok);
    vectors++; if ({ok, init_error, error_code} !== 5'b11_101) begin miscompares++; $display("FAIL t5_ack_error: got %b expected 11101", {ok, init_error, error_code}); end
    dt = end_cyc - log_issue[4];
    vectors++; if (log_idx[4] !== 6'd2 || dt < ACK_TIMEOUT || dt > ACK_TIMEOUT + 2) begin miscompares++; $display("FAIL t5_ack_time: idx %0d after %0d cycles expected 2 after %0d..%0d", log_idx[4], dt, ACK_TIMEOUT, ACK_TIMEOUT + 2); end
    cfg_defaults();
    cfg_hang_idx = 0;
    pulse_start();
    serve(6000, ok);
    cmd_busy = 1'b0;
    vectors++; if ({ok, init_error, error_code} !== 5'b11_100) begin miscompares++; $display("FAIL t5_wd_error: got %b expected 11100", {ok, init_error, error_code}); end
    dt = end_cyc - log_issue[0];
    vectors++; if (dt < WATCHDOG || dt > WATCHDOG + 3) begin miscompares++; $display("FAIL t5_wd_time: got %0d cycles expected %0d..%0d", dt, WATCHDOG, WATCHDOG + 3); end
  endtask

  // Reset mid ACMD41, then start pulses during a busy sequence are ignored.
  task automatic test_reset_and_busy_start();
    bit ok;
    int extra;
    int n_cmd0;
    cfg_defaults();
    cfg_hang_idx     = 41;
    cfg_stop_in_hang = 1'b1;
    pulse_start();
    serve(1000, ok);
    vectors++; if ({ok, seq_busy, cmd_index} !== {2'b11, 6'd41}) begin miscompares++; $display("FAIL t6_in_acmd41: got %b/%b/%0d expected 1/1/41", ok, seq_busy, cmd_index); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if ({new_cmd, seq_busy, init_done, init_error, error_code} !== 7'h0) begin miscompares++; $display("FAIL t6_reset_status: got %b expected 0", {new_cmd, seq_busy, init_done, init_error, error_code}); end
    vectors++; if ({rca, card_v2, card_ccs, cmd_index, cmd_arg} !== 56'h0) begin miscompares++; $display("FAIL t6_reset_data: got %h expected 0", {rca, card_v2, card_ccs, cmd_index, cmd_arg}); end
    reset = 1'b0;
    cmd_busy = 1'b0;
    extra = 0;
    repeat (20) begin @(negedge clk); if (new_cmd) extra++; end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL t6_quiet: got %0d commands expected 0", extra); end
    cfg_defaults();
    cfg_extra_start = 1'b1;
    pulse_start();
    serve(2000, ok);
    n_cmd0 = 0;
    for (int i = 0; i < n_cmds; i++) if (log_idx[i] == 6'd0) n_cmd0++;
    vectors++; if ({ok, init_done} !== 2'b11) begin miscompares++; $display("FAIL t6_busy_start_done: got %b expected 11", {ok, init_done}); end
    vectors++; if (n_cmds !== 7 || n_cmd0 !== 1) begin miscompares++; $display("FAIL t6_busy_start_ignored: got %0d cmds %0d CMD0 expected 7 and 1", n_cmds, n_cmd0); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cmd_busy = 1'b0;
    cmd_complete = 1'b0;
    timeout_error = 1'b0;
    response_status = 32'h0;
    cfg_defaults();
    test_reset();
    test_full_v2();
    test_v1_card();
    test_cmd8_error_restart();
    test_acmd41_limit();
    test_timeouts();
    test_reset_and_busy_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
